// File: rtl/event_rec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : event_rec_pkg
// Description : Shared constants and types for the counter event recorder.
// Revision    : 1.0 - initial release
// ============================================================================
package event_rec_pkg;

  localparam int EV_WIDTH = 8;
  localparam int EV_DEPTH = 4;
  localparam int EV_LVL_W = $clog2(EV_DEPTH) + 1;

  typedef logic [EV_WIDTH-1:0] ev_word_t;
  typedef logic [EV_LVL_W-1:0] ev_level_t;

endpackage : event_rec_pkg
`default_nettype wire

// File: rtl/event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : event_fifo
// Description : Synchronous show-ahead FIFO. Head is visible on data_o while
//               valid_o is high and reads as zero when empty. Full/empty come
//               from the occupancy count, so pointers may wrap freely.
// Revision    : 1.0 - initial release
// ============================================================================
module event_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  // A pop on empty is ignored; a push while full is only taken alongside a pop.
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule : event_fifo
`default_nettype wire

// File: rtl/count_event_recorder.sv
`default_nettype none
// ============================================================================
// Module      : count_event_recorder
// Description : Watches the upper nibble of the counter word, records the
//               full word on each nibble change into a show-ahead FIFO, and
//               tracks a sticky overflow flag and a running event count.
// Revision    : 1.0 - initial release
// ============================================================================
module count_event_recorder
  import event_rec_pkg::*;
#(
  parameter  int WIDTH = EV_WIDTH,
  parameter  int DEPTH = EV_DEPTH,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] cct_input,
  input  logic             enable,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic [7:0]       event_count
);

  logic [3:0] prev_nib_q;
  logic       primed_q;
  logic       overflow_q, overflow_d;
  logic [7:0] event_count_q, event_count_d;
  logic       event_w;
  logic       pop_ok;
  logic       push_ok;
  logic       drop;

  // An event needs a primed tracker so the first sample after reset is silent.
  assign event_w = primed_q && enable &&
                   (cct_input[WIDTH-1:WIDTH-4] != prev_nib_q);
  assign pop_ok  = rd_en && rd_valid;
  // When full, a coincident pop frees the slot the new word needs.
  assign push_ok = event_w && (!full || pop_ok);
  assign drop    = event_w && full && !pop_ok;

  assign overflow    = overflow_q;
  assign event_count = event_count_q;

  event_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .clear   (clear),
    .push_i  (push_ok),
    .pop_i   (rd_en),
    .data_i  (cct_input),
    .data_o  (rd_data),
    .valid_o (rd_valid),
    .full_o  (full),
    .level_o (level)
  );

  // Next-state for the sticky overflow flag and the event counter.
  always_comb begin
    overflow_d    = overflow_q | drop;
    event_count_d = event_count_q;
    if (event_w) event_count_d = event_count_q + 8'd1;
  end

  // Nibble tracker follows the input every cycle, independent of enable.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      prev_nib_q    <= '0;
      primed_q      <= 1'b0;
      overflow_q    <= 1'b0;
      event_count_q <= '0;
    end else begin
      prev_nib_q    <= cct_input[WIDTH-1:WIDTH-4];
      primed_q      <= 1'b1;
      overflow_q    <= overflow_d;
      event_count_q <= event_count_d;
    end
  end

endmodule : count_event_recorder
`default_nettype wire

// File: tb/tb_count_event_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_event_recorder
// Description : Self-checking bench for count_event_recorder with a queue
//               based reference model and directed plus random scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_event_recorder;

  localparam int DEPTH = 4;

  logic       clk;
  logic       clear;
  logic [7:0] cct_input;
  logic       enable;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic [2:0] level;
  logic       overflow;
  logic [7:0] event_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] m_q [$];
  int         m_prev;
  bit         m_primed;
  bit         m_ovf;
  int         m_cnt;

  count_event_recorder #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clear       (clear),
    .cct_input   (cct_input),
    .enable      (enable),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .level       (level),
    .overflow    (overflow),
    .event_count (event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_prev   = 0;
    m_primed = 0;
    m_ovf    = 0;
    m_cnt    = 0;
  endtask

  // Drive one cycle, advance the model by the same edge, settle 1 time unit after.
  task automatic step(input logic [7:0] w, input logic en, input logic rd);
    bit ev;
    bit popok;
    bit pushok;
    cct_input = w;
    enable    = en;
    rd_en     = rd;
    @(posedge clk);
    ev     = m_primed && en && (int'(w >> 4) != m_prev);
    popok  = rd && (m_q.size() > 0);
    pushok = 0;
    if (ev) begin
      m_cnt = (m_cnt + 1) % 256;
      if (m_q.size() < DEPTH || popok) pushok = 1;
      else m_ovf = 1;
    end
    if (popok)  void'(m_q.pop_front());
    if (pushok) m_q.push_back(w);
    m_prev   = int'(w >> 4);
    m_primed = 1;
    #1;
  endtask

  task automatic ramp(input int lo, input int hi, input logic en);
    for (int i = lo; i <= hi; i++) step(8'(i), en, 1'b0);
  endtask

  // Asynchronous clear pulse placed between edges.
  task automatic do_clear();
    clear = 1'b1;
    #2;
    model_reset();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    do_clear();
    ramp(0, 8'h3F, 1'b1);
    checks++;
    if (level !== 3'd3) begin errors++; $display("FAIL reset_prefill level=%0d want 3", level); end
    // Assert clear mid-cycle and look before the next edge.
    clear = 1'b1;
    #2;
    checks++;
    if ({rd_data, rd_valid, full, level, overflow, event_count} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset data=%h valid=%b full=%b level=%0d ovf=%b cnt=%0d want all 0",
               rd_data, rd_valid, full, level, overflow, event_count);
    end
    model_reset();
    clear = 1'b0;
  endtask

  task automatic test_single_event();
    do_clear();
    ramp(0, 8'h1F, 1'b1);
    checks++;
    if (rd_data !== 8'h10) begin errors++; $display("FAIL single_data got %h want 10", rd_data); end
    checks++;
    if (level !== 3'd1) begin errors++; $display("FAIL single_level got %0d want 1", level); end
    checks++;
    if (event_count !== 8'd1) begin errors++; $display("FAIL single_count got %0d want 1", event_count); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    do_clear();
    ramp(0, 8'h5F, 1'b1);
    checks++;
    if (full !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flags full=%b ovf=%b want 1 1", full, overflow);
    end
    checks++;
    if (event_count !== 8'd5) begin errors++; $display("FAIL ovf_count got %0d want 5", event_count); end
    for (int i = 1; i <= 4; i++) begin
      exp = 8'(i * 16);
      checks++;
      if (rd_data !== exp || rd_valid !== 1'b1) begin
        errors++; $display("FAIL ovf_pop%0d data=%h valid=%b want %h 1", i, rd_data, rd_valid, exp);
      end
      step(8'h5F, 1'b1, 1'b1);
    end
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drained valid=%b data=%h ovf=%b want 0 00 1", rd_valid, rd_data, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    do_clear();
    ramp(0, 8'h4F, 1'b1);
    step(8'h50, 1'b1, 1'b1);
    checks++;
    if (level !== 3'd4 || rd_data !== 8'h20 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_pushpop level=%0d data=%h ovf=%b want 4 20 0", level, rd_data, overflow);
    end
    checks++;
    if (event_count !== 8'd5) begin errors++; $display("FAIL full_pushpop_count got %0d want 5", event_count); end
  endtask

  task automatic test_empty_pop();
    do_clear();
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1, 1'b1);
    checks++;
    if (level !== 3'd0 || rd_data !== 8'h00 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL empty_pop level=%0d data=%h valid=%b want 0 00 0", level, rd_data, rd_valid);
    end
    ramp(1, 8'h10, 1'b1);
    checks++;
    if (level !== 3'd1 || rd_data !== 8'h10) begin
      errors++; $display("FAIL empty_then_event level=%0d data=%h want 1 10", level, rd_data);
    end
    // Push and pop together on empty: pop ignored, level becomes 1.
    step(8'h10, 1'b1, 1'b1);
    step(8'h20, 1'b1, 1'b1);
    checks++;
    if (level !== 3'd1 || rd_data !== 8'h20) begin
      errors++; $display("FAIL empty_pushpop level=%0d data=%h want 1 20", level, rd_data);
    end
  endtask

  task automatic test_enable();
    do_clear();
    ramp(0, 8'h3F, 1'b1);
    ramp(8'h40, 8'h4F, 1'b0);
    checks++;
    if (level !== 3'd3 || event_count !== 8'd3) begin
      errors++; $display("FAIL enable_off level=%0d cnt=%0d want 3 3", level, event_count);
    end
    step(8'h50, 1'b1, 1'b0);
    checks++;
    if (level !== 3'd4 || event_count !== 8'd4) begin
      errors++; $display("FAIL enable_on level=%0d cnt=%0d want 4 4", level, event_count);
    end
    for (int i = 0; i < 3; i++) step(8'h50, 1'b1, 1'b1);
    checks++;
    if (rd_data !== 8'h50) begin errors++; $display("FAIL enable_readback got %h want 50", rd_data); end
  endtask

  // Random words and ramps, every output compared to the model every cycle.
  task automatic test_random();
    logic [7:0] w;
    logic [7:0] exp_data;
    int         cnt_seen_wrap;
    do_clear();
    w = 8'h00;
    cnt_seen_wrap = 0;
    for (int c = 0; c < 900; c++) begin
      if (c < 400) w = 8'($urandom);
      else if ($urandom_range(0, 9) == 0) w = 8'($urandom);
      else w = w + 8'd1;
      step(w, ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0));
      if (m_cnt < 10 && c > 300) cnt_seen_wrap = 1;
      exp_data = (m_q.size() > 0) ? m_q[0] : 8'h00;
      checks++;
      if (rd_data !== exp_data || rd_valid !== (m_q.size() > 0)) begin
        errors++; $display("FAIL rand_head c=%0d data=%h valid=%b want %h %b", c, rd_data, rd_valid, exp_data, m_q.size() > 0);
      end
      checks++;
      if (level !== 3'(m_q.size()) || full !== (m_q.size() == DEPTH)) begin
        errors++; $display("FAIL rand_level c=%0d level=%0d full=%b want %0d %b", c, level, full, m_q.size(), m_q.size() == DEPTH);
      end
      checks++;
      if (overflow !== m_ovf || event_count !== 8'(m_cnt)) begin
        errors++; $display("FAIL rand_stat c=%0d ovf=%b cnt=%0d want %b %0d", c, overflow, event_count, m_ovf, m_cnt);
      end
    end
    checks++;
    if (cnt_seen_wrap != 1) begin errors++; $display("FAIL rand_wrap got %0d want 1", cnt_seen_wrap); end
  endtask

  initial begin
    clear     = 1'b1;
    cct_input = 8'h00;
    enable    = 1'b0;
    rd_en     = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({rd_data, rd_valid, full, level, overflow, event_count} !== 22'd0) begin
      errors++; $display("FAIL power_on_reset outputs=%h want 0", {rd_data, rd_valid, full, level, overflow, event_count});
    end
    clear = 1'b0;
    test_reset();
    test_single_event();
    test_overflow();
    test_full_push_pop();
    test_empty_pop();
    test_enable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_count_event_recorder
`default_nettype wire
